// File: rtl/mmu_skew_feeder.sv
// rtl/mmu_skew_feeder.sv - row-to-skewed-lane feeder for a depth x depth systolic MMU.
// Lane k delays its element by k+1 registers so diagonals line up in the array.
module mmu_skew_feeder #(
  parameter int depth     = 3,
  parameter int bit_width = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [bit_width*depth-1:0] in_row,
  input  logic                       in_last,
  output logic [bit_width*depth-1:0] data_arr,
  output logic                       control,
  output logic                       busy,
  output logic                       done,
  output logic [7:0]                 row_count
);

  localparam int CW = (depth > 1) ? $clog2(depth + 1) : 1;

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

  state_t            state;
  logic [CW-1:0]     drain_cnt;
  logic [depth-1:0]  lane_tag;
  logic              accept;

  assign accept  = in_valid && in_ready;
  assign control = |lane_tag;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      drain_cnt <= '0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      row_count <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            row_count <= 8'd1;
            busy      <= 1'b1;
            if (in_last) begin
              state     <= DRAIN;
              drain_cnt <= CW'(depth - 1);
              in_ready  <= 1'b0;
            end else begin
              state <= STREAM;
            end
          end
        end
        STREAM: begin
          if (accept) begin
            row_count <= row_count + 8'd1;
            if (in_last) begin
              state     <= DRAIN;
              drain_cnt <= CW'(depth - 1);
              in_ready  <= 1'b0;
            end
          end
        end
        DRAIN: begin
          // Counter covers exactly the depth cycles the last row needs to clear lane depth-1.
          if (drain_cnt == '0) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - CW'(1);
          end
        end
        DONE: begin
          state    <= IDLE;
          done     <= 1'b0;
          busy     <= 1'b0;
          in_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < depth; k++) begin : g_lane
    logic [bit_width-1:0] stage_data [k+1];
    logic                 stage_tag  [k+1];

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        for (int j = 0; j <= k; j++) begin
          stage_data[j] <= '0;
          stage_tag[j]  <= 1'b0;
        end
      end else begin
        // Non-accept cycles inject a tagged-off zero so bubbles never carry stale data.
        stage_data[0] <= accept ? in_row[k*bit_width +: bit_width] : '0;
        stage_tag[0]  <= accept;
        for (int j = 1; j <= k; j++) begin
          stage_data[j] <= stage_data[j-1];
          stage_tag[j]  <= stage_tag[j-1];
        end
      end
    end

    assign data_arr[k*bit_width +: bit_width] = stage_tag[k] ? stage_data[k] : '0;
    assign lane_tag[k] = stage_tag[k];
  end

endmodule

// File: tb/tb_mmu_skew_feeder.sv
// tb/tb_mmu_skew_feeder.sv - directed self-checking bench for mmu_skew_feeder (depth=3, bit_width=8).
module tb_mmu_skew_feeder;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_row;
  logic        in_last;
  logic [23:0] data_arr;
  logic        control;
  logic        busy;
  logic        done;
  logic [7:0]  row_count;

  int checks   = 0;
  int failures = 0;

  mmu_skew_feeder #(.depth(3), .bit_width(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_row    (in_row),
    .in_last   (in_last),
    .data_arr  (data_arr),
    .control   (control),
    .busy      (busy),
    .done      (done),
    .row_count (row_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [23:0] row, input logic last);
    in_valid = v;
    in_row   = row;
    in_last  = last;
  endtask

  task automatic chk_out(input string tag, input logic [23:0] d, input logic c, input logic dn);
    chk({tag, "_data"}, 32'(data_arr), 32'(d));
    chk({tag, "_control"}, 32'(control), 32'(c));
    chk({tag, "_done"}, 32'(done), 32'(dn));
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b0, 24'h0, 1'b0);
    #2;
    chk_out("reset", 24'h0, 1'b0, 1'b0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_row_count", 32'(row_count), 32'd0);
    tick(); tick();
    #3 reset = 1'b1;
    #1;
    chk("post_reset_in_ready", 32'(in_ready), 32'd1);
    chk("post_reset_busy", 32'(busy), 32'd0);

    // Single row
    drive(1'b1, 24'h030201, 1'b1);
    tick(); drive(1'b0, 24'h0, 1'b0);
    chk_out("single_t1", 24'h000001, 1'b1, 1'b0);
    chk("single_row_count", 32'(row_count), 32'd1);
    chk("single_in_ready_drain", 32'(in_ready), 32'd0);
    chk("single_busy", 32'(busy), 32'd1);
    tick(); chk_out("single_t2", 24'h000200, 1'b1, 1'b0);
    tick(); chk_out("single_t3", 24'h030000, 1'b1, 1'b0);
    tick(); chk_out("single_t4", 24'h000000, 1'b0, 1'b1);
    chk("single_busy_done", 32'(busy), 32'd1);
    tick(); chk_out("single_t5", 24'h000000, 1'b0, 1'b0);
    chk("single_idle_busy", 32'(busy), 32'd0);
    chk("single_idle_ready", 32'(in_ready), 32'd1);

    // Three rows back-to-back
    drive(1'b1, 24'h030201, 1'b0);
    tick(); chk_out("b2b_t1", 24'h000001, 1'b1, 1'b0);
    drive(1'b1, 24'h060504, 1'b0);
    tick(); chk_out("b2b_t2", 24'h000204, 1'b1, 1'b0);
    drive(1'b1, 24'h090807, 1'b1);
    tick(); chk_out("b2b_t3", 24'h030507, 1'b1, 1'b0);
    drive(1'b0, 24'h0, 1'b0);
    tick(); chk_out("b2b_t4", 24'h060800, 1'b1, 1'b0);
    tick(); chk_out("b2b_t5", 24'h090000, 1'b1, 1'b0);
    tick(); chk_out("b2b_t6", 24'h000000, 1'b0, 1'b1);
    chk("b2b_row_count", 32'(row_count), 32'd3);
    tick(); chk("b2b_idle_ready", 32'(in_ready), 32'd1);

    // Bubble between two rows
    drive(1'b1, 24'h030201, 1'b0);
    tick(); chk_out("bub_t1", 24'h000001, 1'b1, 1'b0);
    drive(1'b0, 24'h0, 1'b0);
    tick(); chk_out("bub_t2", 24'h000200, 1'b1, 1'b0);
    drive(1'b1, 24'h060504, 1'b1);
    tick(); chk_out("bub_t3", 24'h030004, 1'b1, 1'b0);
    drive(1'b0, 24'h0, 1'b0);
    tick(); chk_out("bub_t4", 24'h000500, 1'b1, 1'b0);
    tick(); chk_out("bub_t5", 24'h060000, 1'b1, 1'b0);
    tick(); chk_out("bub_t6", 24'h000000, 1'b0, 1'b1);
    chk("bub_row_count", 32'(row_count), 32'd2);
    tick();

    // in_valid held through DRAIN/DONE is ignored
    drive(1'b1, 24'h030201, 1'b1);
    tick(); drive(1'b1, 24'h0C0B0A, 1'b1);
    chk_out("bp_t1", 24'h000001, 1'b1, 1'b0);
    tick(); chk_out("bp_t2", 24'h000200, 1'b1, 1'b0);
    chk("bp_ready_t2", 32'(in_ready), 32'd0);
    tick(); chk_out("bp_t3", 24'h030000, 1'b1, 1'b0);
    chk("bp_row_count_t3", 32'(row_count), 32'd1);
    tick(); chk_out("bp_t4", 24'h000000, 1'b0, 1'b1);
    chk("bp_ready_t4", 32'(in_ready), 32'd0);
    tick(); chk_out("bp_t5", 24'h000000, 1'b0, 1'b0);
    chk("bp_ready_t5", 32'(in_ready), 32'd1);
    chk("bp_row_count_t5", 32'(row_count), 32'd1);
    tick(); drive(1'b0, 24'h0, 1'b0);
    chk_out("bp_t6", 24'h00000A, 1'b1, 1'b0);
    chk("bp_resume_busy", 32'(busy), 32'd1);
    tick(); tick();
    tick(); chk_out("bp_t9", 24'h000000, 1'b0, 1'b1);
    tick();

    // Reset mid-stream
    drive(1'b1, 24'h030201, 1'b0);
    tick(); drive(1'b1, 24'h060504, 1'b0);
    tick(); chk_out("rst_t2", 24'h000204, 1'b1, 1'b0);
    drive(1'b0, 24'h0, 1'b0);
    #3 reset = 1'b0;
    #1;
    chk_out("rst_async", 24'h000000, 1'b0, 1'b0);
    chk("rst_async_busy", 32'(busy), 32'd0);
    chk("rst_async_row_count", 32'(row_count), 32'd0);
    tick(); tick();
    #3 reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_out("rst_no_done", 24'h000000, 1'b0, 1'b0);
    end
    drive(1'b1, 24'h030201, 1'b1);
    tick(); drive(1'b0, 24'h0, 1'b0);
    chk_out("rst_single_t1", 24'h000001, 1'b1, 1'b0);
    chk("rst_single_row_count", 32'(row_count), 32'd1);
    tick(); chk_out("rst_single_t2", 24'h000200, 1'b1, 1'b0);
    tick(); chk_out("rst_single_t3", 24'h030000, 1'b1, 1'b0);
    tick(); chk_out("rst_single_t4", 24'h000000, 1'b0, 1'b1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
